csr_trap_ctrl: RTL and testbench
================================

Name: csr_trap_ctrl

Overview:
- Machine-mode CSR file and trap sequencer for the three-stage RV32 pipeline.
- Owns mstatus, mie, mip, mtvec, mepc and mcause, plus a free-running 32-bit mtime and mtimecmp.
- Takes the machine-timer interrupt at instruction retirement and drives the PC redirect and flush for trap entry and for mret.
- Sits beside the execute/writeback stage; the fetch stage consumes its redirect outputs.

Parameters:
- MTVEC_RST, 32'h0000_0000, reset value of mtvec.
- MTIMECMP_RST, 32'hFFFF_FFFF, reset value of mtimecmp.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  an instruction retires this cycle.
- pc_ex  in  32  PC of the retiring instruction.
- is_mret  in  1  the retiring instruction is mret.
- csr_op  in  2  00 none, 01 write, 10 set bits, 11 clear bits.
- csr_addr  in  12  CSR address.
- csr_wdata  in  32  CSR operand.
- csr_rdata  out  32  combinational read of csr_addr; 0 for an unmapped address.
- trap_taken  out  1  one-cycle trap-entry redirect.
- trap_pc  out  32  {mtvec[31:2],2'b00}; valid while trap_taken=1.
- epc_taken  out  1  one-cycle mret redirect.
- epc  out  32  mepc; valid while epc_taken=1.
- flush  out  1  kill younger instructions; asserted with either redirect.
- timer_irq  out  1  mip.MTIP.

Behaviour:
- Clock and reset: clk, rst_n; reset is asynchronous, active-low.
- CSR map:
  - mstatus 0x300: MIE bit3, MPIE bit7; all other bits read 0.
  - mie 0x304: MTIE bit7 only.
  - mtvec 0x305.
  - mepc 0x341: bits[1:0] forced 0.
  - mcause 0x342.
  - mip 0x344: read-only, MTIP bit7.
  - mtimecmp 0x7C0.
  - mtime 0x7C1.
- Reset:
  - All CSRs 0, except mtvec=MTVEC_RST and mtimecmp=MTIMECMP_RST.
  - State RUN; all redirect outputs 0.
- Timer:
  - mtime increments by 1 every cycle and wraps FFFF_FFFF->0.
  - A CSR write to mtime overrides that cycle's increment.
  - MTIP = (mtime >= mtimecmp), unsigned, registered; it is visible the cycle after the compare holds.
- CSR writes:
  - Performed at the clock edge only when state=RUN, instr_valid=1 and no trap is taken that cycle.
  - set: reg|wdata; clear: reg&~wdata.
  - Writes to mip or to unmapped addresses are ignored.
  - csr_rdata returns the pre-write value.
- pending = MTIP & mie.MTIE & mstatus.MIE.
- FSM states: RUN, TRAP, RET.
- RUN, pending & instr_valid:
  - mepc<=pc_ex, mcause<=32'h8000_0007, MPIE<=MIE, MIE<=0.
  - The retiring instruction's CSR op and mret are suppressed; next state TRAP.
- RUN, is_mret & instr_valid & !pending:
  - MIE<=MPIE, MPIE<=1; next state RET.
- RUN, otherwise: stay in RUN.
- TRAP:
  - trap_taken=1, flush=1, trap_pc driven; next state RUN.
- RET:
  - epc_taken=1, flush=1, epc=mepc; next state RUN.
- In TRAP and RET, instr_valid, csr_op and is_mret are ignored; a CSR op arriving then is dropped.
- Redirect latency: exactly 1 cycle after the retirement cycle. trap_taken and epc_taken are never asserted together.
- Interrupt and mret in the same cycle: the interrupt wins; mepc holds the mret's PC so mret is replayed after the handler.
- With instr_valid=0 while pending=1, the trap waits for the next retirement.
- Reset asserted in TRAP or RET aborts the redirect immediately; outputs go to 0 asynchronously.

Test Plan:
- Reset, then read every CSR -> mtvec=MTVEC_RST, mtimecmp=FFFF_FFFF, all others 0; trap_taken=epc_taken=flush=0.
- Write mtvec=0x100, set mie=0x80 and mstatus=0x08, write mtimecmp=mtime+5, retire with pc_ex=0x40 each cycle:
  - timer_irq rises.
  - Next retirement -> trap_taken=1, trap_pc=0x100, flush=1 for one cycle.
  - mepc=0x40, mcause=0x8000_0007, mstatus=0x80.
- From the handler, retire mret -> next cycle epc_taken=1, epc=mepc, flush=1; mstatus=0x88.
- MTIP=1 with mstatus.MIE=0 -> no trap. Then set MIE in the same cycle as retiring a CSR write -> write lands; trap follows on the next retirement.
- Interrupt pending while retiring mret at pc 0x80 -> trap_taken, epc_taken=0, mepc=0x80, MIE unchanged by the mret.
- Write mtime=FFFF_FFFE -> reads FFFF_FFFF one cycle later, then 0 after wrap. Assert rst_n=0 during TRAP -> trap_taken drops immediately.

Source files
------------

// File: rtl/csr_trap_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : csr_trap_if -- retirement/CSR bus between execute stage and CSR block
// Rev    : 1.0  initial release
// ============================================================================
interface csr_trap_if;
  logic        instr_valid;
  logic [31:0] pc_ex;
  logic        is_mret;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        trap_taken;
  logic [31:0] trap_pc;
  logic        epc_taken;
  logic [31:0] epc;
  logic        flush;
  logic        timer_irq;

  modport master (
    output instr_valid, pc_ex, is_mret, csr_op, csr_addr, csr_wdata,
    input  csr_rdata, trap_taken, trap_pc, epc_taken, epc, flush, timer_irq
  );

  modport slave (
    input  instr_valid, pc_ex, is_mret, csr_op, csr_addr, csr_wdata,
    output csr_rdata, trap_taken, trap_pc, epc_taken, epc, flush, timer_irq
  );
endinterface
`default_nettype wire

// File: rtl/csr_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module : csr_trap_ctrl -- M-mode CSR file, mtime/mtimecmp and trap sequencer
// Rev    : 1.0  initial release
// ============================================================================
module csr_trap_ctrl #(
  parameter logic [31:0] MTVEC_RST    = 32'h0000_0000,
  parameter logic [31:0] MTIMECMP_RST = 32'hFFFF_FFFF
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  csr_trap_if.slave   bus
);

  localparam logic [11:0] c_MSTATUS  = 12'h300;
  localparam logic [11:0] c_MIE      = 12'h304;
  localparam logic [11:0] c_MTVEC    = 12'h305;
  localparam logic [11:0] c_MEPC     = 12'h341;
  localparam logic [11:0] c_MCAUSE   = 12'h342;
  localparam logic [11:0] c_MIP      = 12'h344;
  localparam logic [11:0] c_MTIMECMP = 12'h7C0;
  localparam logic [11:0] c_MTIME    = 12'h7C1;

  localparam logic [1:0] c_OP_WRITE = 2'b01;
  localparam logic [1:0] c_OP_SET   = 2'b10;
  localparam logic [1:0] c_OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_TRAP = 2'd1,
    ST_RET  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic        mie_mtie_q, mie_mtie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic        mtip_q, mtip_d;
  logic [31:0] mtime_q, mtime_d;
  logic [31:0] mtimecmp_q, mtimecmp_d;

  logic [31:0] rdata;
  logic [31:0] wval;
  logic        pending;
  logic        trap_taken, epc_taken, flush;
  logic [31:0] trap_pc, epc;
  logic        unused_pc_lsb;

  assign unused_pc_lsb = ^bus.pc_ex[1:0];

  always_comb begin
    rdata = 32'h0;
    case (bus.csr_addr)
      c_MSTATUS:  rdata = {24'h0, mstatus_mpie_q, 3'b000, mstatus_mie_q, 3'b000};
      c_MIE:      rdata = {24'h0, mie_mtie_q, 7'h0};
      c_MTVEC:    rdata = mtvec_q;
      c_MEPC:     rdata = mepc_q;
      c_MCAUSE:   rdata = mcause_q;
      c_MIP:      rdata = {24'h0, mtip_q, 7'h0};
      c_MTIMECMP: rdata = mtimecmp_q;
      c_MTIME:    rdata = mtime_q;
      default:    rdata = 32'h0;
    endcase
  end

  always_comb begin
    wval = bus.csr_wdata;
    case (bus.csr_op)
      c_OP_SET:   wval = rdata | bus.csr_wdata;
      c_OP_CLEAR: wval = rdata & ~bus.csr_wdata;
      default:    wval = bus.csr_wdata;
    endcase
  end

  assign pending = mtip_q & mie_mtie_q & mstatus_mie_q;

  always_comb begin
    state_d        = state_q;
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_mtie_d     = mie_mtie_q;
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtime_d        = mtime_q + 32'd1;
    mtimecmp_d     = mtimecmp_q;
    mtip_d         = (mtime_q >= mtimecmp_q);
    trap_taken     = 1'b0;
    epc_taken      = 1'b0;
    flush          = 1'b0;
    trap_pc        = 32'h0;
    epc            = 32'h0;

    case (state_q)
      ST_RUN: begin
        if (bus.instr_valid) begin
          if (pending) begin
            // Interrupt wins over the retiring op; mepc points at it so it replays.
            mepc_d         = {bus.pc_ex[31:2], 2'b00};
            mcause_d       = 32'h8000_0007;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
            state_d        = ST_TRAP;
          end else begin
            if (bus.csr_op != 2'b00) begin
              case (bus.csr_addr)
                c_MSTATUS: begin
                  mstatus_mie_d  = wval[3];
                  mstatus_mpie_d = wval[7];
                end
                c_MIE:      mie_mtie_d = wval[7];
                c_MTVEC:    mtvec_d    = wval;
                c_MEPC:     mepc_d     = {wval[31:2], 2'b00};
                c_MCAUSE:   mcause_d   = wval;
                c_MTIMECMP: mtimecmp_d = wval;
                c_MTIME:    mtime_d    = wval;
                default:    ;
              endcase
            end
            if (bus.is_mret) begin
              mstatus_mie_d  = mstatus_mpie_q;
              mstatus_mpie_d = 1'b1;
              state_d        = ST_RET;
            end
          end
        end
      end
      ST_TRAP: begin
        trap_taken = 1'b1;
        flush      = 1'b1;
        trap_pc    = {mtvec_q[31:2], 2'b00};
        state_d    = ST_RUN;
      end
      ST_RET: begin
        epc_taken = 1'b1;
        flush     = 1'b1;
        epc       = mepc_q;
        state_d   = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_mtie_q     <= 1'b0;
      mtvec_q        <= MTVEC_RST;
      mepc_q         <= 32'h0;
      mcause_q       <= 32'h0;
      mtip_q         <= 1'b0;
      mtime_q        <= 32'h0;
      mtimecmp_q     <= MTIMECMP_RST;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_mtie_q     <= mie_mtie_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtip_q         <= mtip_d;
      mtime_q        <= mtime_d;
      mtimecmp_q     <= mtimecmp_d;
    end
  end

  assign bus.csr_rdata  = rdata;
  assign bus.trap_taken = trap_taken;
  assign bus.trap_pc    = trap_pc;
  assign bus.epc_taken  = epc_taken;
  assign bus.epc        = epc;
  assign bus.flush      = flush;
  assign bus.timer_irq  = mtip_q;

endmodule
`default_nettype wire

// File: tb/tb_csr_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_csr_trap_ctrl -- self-checking bench for csr_trap_ctrl
// Rev    : 1.0  initial release
// ============================================================================
module tb_csr_trap_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  csr_trap_if bus ();

  csr_trap_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [1:0] OP_N = 2'b00;
  localparam logic [1:0] OP_W = 2'b01;
  localparam logic [1:0] OP_S = 2'b10;
  localparam logic [1:0] OP_C = 2'b11;

  typedef struct packed {
    logic        trap;
    logic        ret;
    logic        flush;
    logic [31:0] tpc;
    logic [31:0] epc;
  } redir_t;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
  } vec_t;

  int     errors = 0;
  int     checks = 0;
  redir_t sb_q[$];
  vec_t   tbl[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic redir_t none_r();
    return '0;
  endfunction

  function automatic redir_t trap_r(input logic [31:0] tpc);
    redir_t r;
    r = '0; r.trap = 1'b1; r.flush = 1'b1; r.tpc = tpc;
    return r;
  endfunction

  function automatic redir_t ret_r(input logic [31:0] epc);
    redir_t r;
    r = '0; r.ret = 1'b1; r.flush = 1'b1; r.epc = epc;
    return r;
  endfunction

  task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
    bus.csr_addr = a;
    bus.csr_op   = OP_N;
    #1;
    check(name, bus.csr_rdata, exp);
  endtask

  // One cycle of retirement: drive, optionally check rdata, queue the expected
  // redirect, clock, then compare what the DUT presents after the edge.
  task automatic retire(input string name, input logic v, input logic [31:0] pc,
                        input logic mret, input logic [1:0] op, input logic [11:0] a,
                        input logic [31:0] wd, input logic chk, input logic [31:0] exp_rd,
                        input redir_t exp);
    redir_t e;
    bus.instr_valid = v;
    bus.pc_ex       = pc;
    bus.is_mret     = mret;
    bus.csr_op      = op;
    bus.csr_addr    = a;
    bus.csr_wdata   = wd;
    #1;
    if (chk) check({name, " rdata"}, bus.csr_rdata, exp_rd);
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    bus.is_mret     = 1'b0;
    bus.csr_op      = OP_N;
    e = sb_q.pop_front();
    check({name, " trap_taken"}, {31'h0, bus.trap_taken}, {31'h0, e.trap});
    check({name, " epc_taken"},  {31'h0, bus.epc_taken},  {31'h0, e.ret});
    check({name, " flush"},      {31'h0, bus.flush},      {31'h0, e.flush});
    check({name, " trap_pc"},    bus.trap_pc,             e.tpc);
    check({name, " epc"},        bus.epc,                 e.epc);
  endtask

  task automatic idle(input string name);
    retire(name, 1'b0, 32'h0, 1'b0, OP_N, 12'h000, 32'h0, 1'b0, 32'h0, none_r());
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    bus.instr_valid = 1'b0;
    bus.pc_ex       = 32'h0;
    bus.is_mret     = 1'b0;
    bus.csr_op      = OP_N;
    bus.csr_addr    = 12'h0;
    bus.csr_wdata   = 32'h0;

    tbl[0]  = '{OP_W, 12'h305, 32'h0000_0100, 32'h0000_0000};
    tbl[1]  = '{OP_N, 12'h305, 32'h0000_0000, 32'h0000_0100};
    tbl[2]  = '{OP_S, 12'h305, 32'h0000_0003, 32'h0000_0100};
    tbl[3]  = '{OP_C, 12'h305, 32'h0000_0001, 32'h0000_0103};
    tbl[4]  = '{OP_N, 12'h305, 32'h0000_0000, 32'h0000_0102};
    tbl[5]  = '{OP_W, 12'h341, 32'h0000_0123, 32'h0000_0000};
    tbl[6]  = '{OP_N, 12'h341, 32'h0000_0000, 32'h0000_0120};
    tbl[7]  = '{OP_W, 12'h342, 32'hDEAD_BEEF, 32'h0000_0000};
    tbl[8]  = '{OP_C, 12'h342, 32'hFFFF_0000, 32'hDEAD_BEEF};
    tbl[9]  = '{OP_N, 12'h342, 32'h0000_0000, 32'h0000_BEEF};
    tbl[10] = '{OP_W, 12'h304, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[11] = '{OP_N, 12'h304, 32'h0000_0000, 32'h0000_0080};
    tbl[12] = '{OP_W, 12'h300, 32'hFFFF_FFF7, 32'h0000_0000};
    tbl[13] = '{OP_N, 12'h300, 32'h0000_0000, 32'h0000_0080};
    tbl[14] = '{OP_W, 12'h344, 32'h0000_FFFF, 32'h0000_0000};
    tbl[15] = '{OP_N, 12'h344, 32'h0000_0000, 32'h0000_0000};
    tbl[16] = '{OP_W, 12'h123, 32'h0000_FFFF, 32'h0000_0000};
    tbl[17] = '{OP_N, 12'h123, 32'h0000_0000, 32'h0000_0000};
    tbl[18] = '{OP_W, 12'h7C0, 32'h0000_1000, 32'hFFFF_FFFF};
    tbl[19] = '{OP_N, 12'h7C0, 32'h0000_0000, 32'h0000_1000};

    // Reset values, read while reset is held so mtime is still 0
    #12;
    rd("rst mstatus",  12'h300, 32'h0);
    rd("rst mie",      12'h304, 32'h0);
    rd("rst mtvec",    12'h305, 32'h0);
    rd("rst mepc",     12'h341, 32'h0);
    rd("rst mcause",   12'h342, 32'h0);
    rd("rst mip",      12'h344, 32'h0);
    rd("rst mtimecmp", 12'h7C0, 32'hFFFF_FFFF);
    rd("rst mtime",    12'h7C1, 32'h0);
    rd("rst unmapped", 12'h123, 32'h0);
    check("rst trap_taken", {31'h0, bus.trap_taken}, 32'h0);
    check("rst epc_taken",  {31'h0, bus.epc_taken},  32'h0);
    check("rst flush",      {31'h0, bus.flush},      32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++)
      retire($sformatf("vec%0d", i), 1'b1, 32'h10, 1'b0, tbl[i].op, tbl[i].addr,
             tbl[i].wd, 1'b1, tbl[i].rd, none_r());

    // Timer interrupt entry
    retire("mtvec_w", 1'b1, 32'h40, 1'b0, OP_W, 12'h305, 32'h100, 1'b1, 32'h102, none_r());
    retire("mie_set", 1'b1, 32'h40, 1'b0, OP_S, 12'h300, 32'h08,  1'b1, 32'h80,  none_r());
    retire("mtime_w", 1'b1, 32'h40, 1'b0, OP_W, 12'h7C1, 32'hFFA, 1'b0, 32'h0,   none_r());
    cnt = 0;
    while (!bus.timer_irq && cnt < 20) begin
      retire("wait_irq", 1'b1, 32'h40, 1'b0, OP_N, 12'h0, 32'h0, 1'b0, 32'h0, none_r());
      cnt++;
    end
    check("irq_latency", cnt, 32'd7);
    retire("trap1", 1'b1, 32'h40, 1'b0, OP_N, 12'h0, 32'h0, 1'b0, 32'h0, trap_r(32'h100));
    rd("trap1 mepc",    12'h341, 32'h40);
    rd("trap1 mcause",  12'h342, 32'h8000_0007);
    rd("trap1 mstatus", 12'h300, 32'h80);
    retire("drop_in_trap", 1'b1, 32'h44, 1'b0, OP_W, 12'h305, 32'h200, 1'b1, 32'h100, none_r());
    rd("mtvec kept", 12'h305, 32'h100);

    // mret from handler, then interrupt against a retiring mret
    retire("mret1", 1'b1, 32'h60, 1'b1, OP_N, 12'h0, 32'h0, 1'b0, 32'h0, ret_r(32'h40));
    rd("mret1 mstatus", 12'h300, 32'h88);
    idle("in_ret");
    idle("pend_no_retire0");
    idle("pend_no_retire1");
    retire("mret_vs_irq", 1'b1, 32'h80, 1'b1, OP_N, 12'h0, 32'h0, 1'b0, 32'h0, trap_r(32'h100));
    rd("mret_vs_irq mepc",    12'h341, 32'h80);
    rd("mret_vs_irq mstatus", 12'h300, 32'h80);
    idle("in_trap2");

    // MTIP with MIE=0 is masked; setting MIE while retiring lands, trap follows
    check("irq_held", {31'h0, bus.timer_irq}, 32'h1);
    retire("masked0", 1'b1, 32'h84, 1'b0, OP_N, 12'h0, 32'h0, 1'b0, 32'h0, none_r());
    retire("masked1", 1'b1, 32'h84, 1'b0, OP_N, 12'h0, 32'h0, 1'b0, 32'h0, none_r());
    retire("mie_set2", 1'b1, 32'h88, 1'b0, OP_S, 12'h300, 32'h08, 1'b1, 32'h80, none_r());
    retire("trap3", 1'b1, 32'h90, 1'b0, OP_N, 12'h0, 32'h0, 1'b0, 32'h0, trap_r(32'h100));
    rd("trap3 mepc", 12'h341, 32'h90);
    idle("in_trap3");

    // mtime write and wrap
    retire("mtime_wrap_w", 1'b1, 32'h94, 1'b0, OP_W, 12'h7C1, 32'hFFFF_FFFE, 1'b0, 32'h0, none_r());
    rd("mtime_w0", 12'h7C1, 32'hFFFF_FFFE);
    idle("wrap_t1");
    rd("mtime_w1", 12'h7C1, 32'hFFFF_FFFF);
    idle("wrap_t2");
    rd("mtime_w2", 12'h7C1, 32'h0);

    // Reset during TRAP kills the redirect asynchronously
    retire("cmp_zero", 1'b1, 32'h98, 1'b0, OP_W, 12'h7C0, 32'h0, 1'b1, 32'h1000, none_r());
    retire("mie_set3", 1'b1, 32'h9C, 1'b0, OP_S, 12'h300, 32'h08, 1'b1, 32'h80, none_r());
    retire("trap4", 1'b1, 32'hA0, 1'b0, OP_N, 12'h0, 32'h0, 1'b0, 32'h0, trap_r(32'h100));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_in_trap trap_taken", {31'h0, bus.trap_taken}, 32'h0);
    check("rst_in_trap flush",      {31'h0, bus.flush},      32'h0);
    check("rst_in_trap trap_pc",    bus.trap_pc,             32'h0);
    rd("rst_in_trap mtvec", 12'h305, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    retire("post_rst", 1'b1, 32'hB0, 1'b0, OP_N, 12'h0, 32'h0, 1'b0, 32'h0, none_r());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
